// File: rtl/traffic_light_controller_n.sv
// Demand-actuated N-phase traffic light controller (green/yellow/all-red, tick-timed).
// Optional emergency preemption is built in when EMERGENCY_PREEMPT_EN is defined.
module traffic_light_controller_n #(
  parameter int unsigned NUM_PHASES  = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned T_GREEN     = 7,
  parameter int unsigned T_MAX_GREEN = 14,
  parameter int unsigned T_YELLOW    = 3,
  parameter int unsigned T_ALLRED    = 1,
  localparam int unsigned PW         = $clog2(NUM_PHASES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic [NUM_PHASES-1:0]   req,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic                    emg,
  input  logic [PW-1:0]           emg_phase,
  output logic                    emg_active,
`endif
  output logic [3*NUM_PHASES-1:0] lights,
  output logic [PW-1:0]           active_phase,
  output logic                    phase_start
);

  localparam logic [1:0] S_ALLRED = 2'd0;
  localparam logic [1:0] S_GREEN  = 2'd1;
  localparam logic [1:0] S_YELLOW = 2'd2;

  localparam logic [CNT_W-1:0] ALLRED_END = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] GREEN_MIN  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] GREEN_MAX  = CNT_W'(T_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(T_YELLOW - 1);

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        timer_q, timer_d;
  logic [PW-1:0]           active_q, active_d;
  logic [3*NUM_PHASES-1:0] lights_q, lights_d;
  logic                    phase_start_q, phase_start_d;

  logic [PW-1:0]           next_phase, green_phase, cand;
  logic                    found;
  logic [NUM_PHASES-1:0]   own_mask;
  logic                    other_req, own_req;
  logic                    emg_preempt, emg_hold;

  assign own_mask  = NUM_PHASES'(1) << active_q;
  assign other_req = |(req & ~own_mask);
  assign own_req   = |(req & own_mask);

  // Round-robin search starting after the active phase; active phase checked last.
  always_comb begin
    found      = 1'b0;
    cand       = '0;
    next_phase = PW'((32'(active_q) + 32'd1) % NUM_PHASES);
    for (int unsigned k = 1; k <= NUM_PHASES; k++) begin
      cand = PW'((32'(active_q) + k) % NUM_PHASES);
      if (!found && req[cand]) begin
        found      = 1'b1;
        next_phase = cand;
      end
    end
  end

`ifdef EMERGENCY_PREEMPT_EN
  logic emg_valid;
  logic emg_active_q, emg_active_d;

  assign emg_valid    = emg && (32'(emg_phase) < NUM_PHASES);
  assign emg_preempt  = emg_valid && (active_q != emg_phase);
  assign emg_hold     = emg_valid && (active_q == emg_phase);
  assign green_phase  = emg_valid ? emg_phase : next_phase;
  assign emg_active_d = emg;
  assign emg_active   = emg_active_q;

  always_ff @(posedge clk) begin
    if (rst) emg_active_q <= 1'b0;
    else     emg_active_q <= emg_active_d;
  end
`else
  assign emg_preempt = 1'b0;
  assign emg_hold    = 1'b0;
  assign green_phase = next_phase;
`endif

  // Next-state and timer logic; timer clears on every state change.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    active_d = active_q;
    case (state_q)
      S_ALLRED: begin
        if (tick) begin
          if (timer_q == ALLRED_END) begin
            state_d  = S_GREEN;
            timer_d  = '0;
            active_d = green_phase;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
      end
      S_GREEN: begin
        if (emg_preempt) begin
          state_d = S_YELLOW;
          timer_d = '0;
        end else if (!emg_hold && tick) begin
          if (timer_q >= GREEN_MIN && (other_req || !own_req || timer_q == GREEN_MAX)) begin
            state_d = S_YELLOW;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
      end
      S_YELLOW: begin
        if (tick) begin
          if (timer_q == YELLOW_END) begin
            state_d = S_ALLRED;
            timer_d = '0;
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_ALLRED;
        timer_d = '0;
      end
    endcase
  end

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    lights_d = {NUM_PHASES{3'b100}};
    for (int unsigned p = 0; p < NUM_PHASES; p++) begin
      if (active_d == PW'(p)) begin
        if (state_d == S_GREEN)  lights_d[3*p +: 3] = 3'b001;
        if (state_d == S_YELLOW) lights_d[3*p +: 3] = 3'b010;
      end
    end
    phase_start_d = (state_d == S_GREEN) && (state_q != S_GREEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_ALLRED;
      timer_q       <= '0;
      active_q      <= PW'(NUM_PHASES - 1);
      lights_q      <= {NUM_PHASES{3'b100}};
      phase_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      active_q      <= active_d;
      lights_q      <= lights_d;
      phase_start_q <= phase_start_d;
    end
  end

  assign lights       = lights_q;
  assign active_phase = active_q;
  assign phase_start  = phase_start_q;

endmodule

// File: tb/tb_traffic_light_controller_n.sv
// Self-checking bench for traffic_light_controller_n (default build, short timings).
// A tick-level interval model is compared every cycle; directed scenarios pin literal timings.
module tb_traffic_light_controller_n;

  localparam int NP   = 4;
  localparam int TG   = 4;
  localparam int TMAX = 8;
  localparam int TY   = 2;
  localparam int TAR  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [3:0]  req;
  logic [11:0] lights;
  logic [1:0]  active_phase;
  logic        phase_start;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int tcnt  = 0;
  bit div3  = 1'b0;
  logic tick_level = 1'b1;

  traffic_light_controller_n #(
    .NUM_PHASES (4),
    .CNT_W      (8),
    .T_GREEN    (TG),
    .T_MAX_GREEN(TMAX),
    .T_YELLOW   (TY),
    .T_ALLRED   (TAR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .req         (req),
    .lights      (lights),
    .active_phase(active_phase),
    .phase_start (phase_start)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Interval model: colour 0 = clearance, 1 = green, 2 = yellow; elapsed counts ticks used.
  int   m_color, m_phase, m_elapsed;
  logic m_start;
  bit   m_valid = 1'b0;

  function automatic int pick_next(int cur, logic [NP-1:0] r);
    for (int k = 1; k <= NP; k++)
      if (r[2'((cur + k) % NP)]) return (cur + k) % NP;
    return (cur + 1) % NP;
  endfunction

  function automatic logic [11:0] exp_lights(int color, int ph);
    logic [11:0] v;
    v = {4{3'b100}};
    if (color == 1) v[3*ph +: 3] = 3'b001;
    if (color == 2) v[3*ph +: 3] = 3'b010;
    return v;
  endfunction

  always @(posedge clk) begin
    int  n;
    bit  others;
    cyc++;
    m_start = 1'b0;
    if (rst) begin
      m_valid   = 1'b1;
      m_color   = 0;
      m_phase   = NP - 1;
      m_elapsed = 0;
    end else if (m_valid && tick) begin
      n = m_elapsed + 1;
      others = 1'b0;
      for (int p = 0; p < NP; p++) if (p != m_phase && req[2'(p)]) others = 1'b1;
      if (m_color == 0 && n >= TAR) begin
        m_color = 1; m_phase = pick_next(m_phase, req); m_elapsed = 0; m_start = 1'b1;
      end else if (m_color == 1 && n >= TG && (others || !req[2'(m_phase)] || n >= TMAX)) begin
        m_color = 2; m_elapsed = 0;
      end else if (m_color == 2 && n >= TY) begin
        m_color = 0; m_elapsed = 0;
      end else begin
        m_elapsed = n;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_lights", 32'(lights), 32'(exp_lights(m_color, m_phase)));
      check("model_active", 32'(active_phase), 32'(m_phase));
      check("model_start",  32'(phase_start), 32'(m_start));
    end
  end

  task automatic nstep();
    @(negedge clk);
    tcnt++;
    tick = div3 ? (tcnt % 3 == 0) : tick_level;
  endtask

  task automatic wait_start(output int c, output logic [1:0] ph);
    c  = -1;
    ph = 2'd0;
    for (int i = 0; i < 200; i++) begin
      nstep();
      if (phase_start === 1'b1) begin
        c  = cyc;
        ph = active_phase;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL wait_start timeout cyc=%0d", cyc);
  endtask

  initial begin
    int c0, c1, n, badcnt;
    logic [1:0] pph;
    int sc[$];
    logic [1:0] sp[$];

    rst = 1'b1; tick = 1'b1; req = 4'b1111;
    nstep(); nstep();
    check("rst_lights", 32'(lights), 32'h924);
    check("rst_active", 32'(active_phase), 32'd3);
    check("rst_start",  32'(phase_start), 32'd0);

    // Full rotation, all approaches demanding
    rst = 1'b0;
    nstep();
    check("first_start",  32'(phase_start), 32'd1);
    check("first_lights", 32'(lights), 32'h921);
    c0 = cyc;
    repeat (4) nstep();
    check("p0_yellow", 32'(lights), 32'h922);
    repeat (2) nstep();
    check("p0_allred", 32'(lights), 32'h924);
    for (int k = 1; k <= 4; k++) begin
      wait_start(c1, pph);
      check("rot_phase",  32'(pph), 32'(k % 4));
      check("rot_period", 32'(c1 - c0), 32'd7);
      c0 = c1;
    end

    // Phases 0 and 2 only
    req = 4'b0101;
    badcnt = 0;
    for (int i = 0; i < 28; i++) begin
      nstep();
      if (lights[5:3] !== 3'b100 || lights[11:9] !== 3'b100) badcnt++;
      if (phase_start === 1'b1) begin sc.push_back(cyc); sp.push_back(active_phase); end
    end
    check("skip_idle_lanes", 32'(badcnt), 32'd0);
    check("skip_count", 32'(sc.size()), 32'd4);
    if (sc.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("skip_phase",  32'(sp[k]), (k % 2 == 0) ? 32'd2 : 32'd0);
        check("skip_period", 32'(sc[k] - ((k == 0) ? c0 : sc[k-1])), 32'd7);
      end
      c0 = sc[3];
    end

    // Lone demand extends green to the maximum
    req = 4'b0001;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      nstep();
      if (lights[2:0] == 3'b001) n++; else break;
    end
    check("max_green_len", 32'(n), 32'd8);
    wait_start(c1, pph);
    check("max_regrant_phase",  32'(pph), 32'd0);
    check("max_regrant_period", 32'(c1 - c0), 32'd11);
    c0 = c1;

    // Demand dropped mid-green: minimum green still honoured
    nstep();
    req = 4'b0000;
    n = 2;
    for (int i = 0; i < 40; i++) begin
      nstep();
      if (lights[2:0] == 3'b001) n++; else break;
    end
    check("min_green_len", 32'(n), 32'd4);
    wait_start(c1, pph);
    check("fallback_phase",  32'(pph), 32'd1);
    check("fallback_period", 32'(c1 - c0), 32'd7);

    // Divided tick: all durations triple
    req = 4'b1111;
    div3 = 1'b1;
    wait_start(c0, pph);
    wait_start(c1, pph);
    check("div3_period", 32'(c1 - c0), 32'd21);
    n = 1;
    for (int i = 0; i < 60; i++) begin
      nstep();
      if (lights[3*pph +: 3] == 3'b001) n++; else break;
    end
    check("div3_green_len", 32'(n), 32'd12);
    check("div3_yellow", 32'(lights[3*pph +: 3]), 32'b010);

    // Tick held low in yellow freezes the lights
    div3 = 1'b0; tick_level = 1'b0; tick = 1'b0;
    badcnt = 0;
    for (int i = 0; i < 10; i++) begin
      nstep();
      if (lights[3*pph +: 3] !== 3'b010 || active_phase !== pph) badcnt++;
    end
    check("freeze_yellow", 32'(badcnt), 32'd0);
    tick_level = 1'b1;

    // Reset during phase 2 yellow
    for (int k = 0; k < 6; k++) begin
      wait_start(c1, pph);
      if (pph == 2'd2) break;
    end
    repeat (4) nstep();
    check("p2_yellow", 32'(lights), 32'h8A4);
    rst = 1'b1;
    nstep();
    check("mid_rst_lights", 32'(lights), 32'h924);
    check("mid_rst_active", 32'(active_phase), 32'd3);
    check("mid_rst_start",  32'(phase_start), 32'd0);
    rst = 1'b0;
    nstep();
    check("post_rst_start",  32'(phase_start), 32'd1);
    check("post_rst_active", 32'(active_phase), 32'd0);
    check("post_rst_lights", 32'(lights), 32'h921);
    repeat (10) nstep();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
